// File: rtl/morse_char_buffer.sv
// Morse code to active-low seven-segment shift buffer with space/backspace/clear; MORSE_DIGITS_EN adds digit decode.
// Latency: a code accepted on edge N is visible on seg/char_count after edge N+2; one code per cycle.
// Backpressure: in_ready is ~freeze registered one cycle; codes already in the pipeline always complete.
module morse_char_buffer #(
    parameter int NUM_DIGITS = 8,
    parameter int ERR_W      = 8
) (
    input  logic                               clk_100Mhz,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [2:0]                         char_len,
    input  logic [4:0]                         char_data,
    input  logic                               freeze,
    output logic [8*NUM_DIGITS-1:0]            seg,
    output logic [$clog2(NUM_DIGITS+1)-1:0]    char_count,
    output logic [ERR_W-1:0]                   err_count
);
    localparam int         CW        = $clog2(NUM_DIGITS + 1);
    localparam logic [7:0] BLANK     = 8'b1111_1111;
    localparam logic [7:0] ERR_GLYPH = 8'b1111_0111;

    typedef enum logic [1:0] {OP_SHIFT, OP_BKSP, OP_CLEAR} op_t;

    logic       s1_vld;
    logic [2:0] s1_len;
    logic [4:0] s1_dat;
    logic       s2_vld;
    op_t        s2_op;
    logic [7:0] s2_glyph;
    logic       s2_err;

    logic [4:0] mask;
    logic [6:0] lut_seg;
    logic       lut_hit;
    op_t        dec_op;
    logic [7:0] dec_glyph;
    logic       dec_err;

    // Symbols above the code length are don't-care; zero them so the lookup sees a canonical key.
    always_comb begin
        case (char_len)
            3'd0:    mask = 5'b00001;
            3'd1:    mask = 5'b00011;
            3'd2:    mask = 5'b00111;
            3'd3:    mask = 5'b01111;
            3'd4:    mask = 5'b11111;
            default: mask = 5'b00000;
        endcase
    end

    always_comb begin
        lut_hit = 1'b1;
        lut_seg = 7'b1110111;
        case ({s1_len, s1_dat})
            {3'd0, 5'b00000}: lut_seg = 7'b0110000;
            {3'd0, 5'b00001}: lut_seg = 7'b1110000;
            {3'd1, 5'b00000}: lut_seg = 7'b1111001;
            {3'd1, 5'b00001}: lut_seg = 7'b0001000;
            {3'd1, 5'b00010}: lut_seg = 7'b0001001;
            {3'd1, 5'b00011}: lut_seg = 7'b0101010;
            {3'd2, 5'b00000}: lut_seg = 7'b0100100;
            {3'd2, 5'b00001}: lut_seg = 7'b1000001;
            {3'd2, 5'b00010}: lut_seg = 7'b1111010;
            {3'd2, 5'b00011}: lut_seg = 7'b0100011;
            {3'd2, 5'b00100}: lut_seg = 7'b1000010;
            {3'd2, 5'b00101}: lut_seg = 7'b0101000;
            {3'd2, 5'b00110}: lut_seg = 7'b0100001;
            {3'd2, 5'b00111}: lut_seg = 7'b0000001;
            {3'd3, 5'b00000}: lut_seg = 7'b1001000;
            {3'd3, 5'b00001}: lut_seg = 7'b1000101;
            {3'd3, 5'b00010}: lut_seg = 7'b0111000;
            {3'd3, 5'b00100}: lut_seg = 7'b1110001;
            {3'd3, 5'b00110}: lut_seg = 7'b0011000;
            {3'd3, 5'b00111}: lut_seg = 7'b1000111;
            {3'd3, 5'b01000}: lut_seg = 7'b1100000;
            {3'd3, 5'b01001}: lut_seg = 7'b0110110;
            {3'd3, 5'b01010}: lut_seg = 7'b0110001;
            {3'd3, 5'b01011}: lut_seg = 7'b1000100;
            {3'd3, 5'b01100}: lut_seg = 7'b0010010;
            {3'd3, 5'b01101}: lut_seg = 7'b0001100;
`ifdef MORSE_DIGITS_EN
            {3'd4, 5'b01111}: lut_seg = 7'b1001111;
            {3'd4, 5'b00111}: lut_seg = 7'b0010010;
            {3'd4, 5'b00011}: lut_seg = 7'b0000110;
            {3'd4, 5'b00001}: lut_seg = 7'b1001100;
            {3'd4, 5'b00000}: lut_seg = 7'b0100100;
            {3'd4, 5'b10000}: lut_seg = 7'b0100000;
            {3'd4, 5'b11000}: lut_seg = 7'b0001111;
            {3'd4, 5'b11100}: lut_seg = 7'b0000000;
            {3'd4, 5'b11110}: lut_seg = 7'b0000100;
            {3'd4, 5'b11111}: lut_seg = 7'b0000001;
`endif
            default:          lut_hit = 1'b0;
        endcase
    end

    always_comb begin
        dec_op    = OP_SHIFT;
        dec_glyph = BLANK;
        dec_err   = 1'b0;
        case (s1_len)
            3'd5:    dec_glyph = BLANK;
            3'd6:    dec_op    = OP_BKSP;
            3'd7:    dec_op    = OP_CLEAR;
            default: begin
                dec_glyph = lut_hit ? {1'b1, lut_seg} : ERR_GLYPH;
                dec_err   = ~lut_hit;
            end
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            in_ready   <= 1'b0;
            s1_vld     <= 1'b0;
            s1_len     <= 3'd0;
            s1_dat     <= 5'd0;
            s2_vld     <= 1'b0;
            s2_op      <= OP_SHIFT;
            s2_glyph   <= BLANK;
            s2_err     <= 1'b0;
            seg        <= '1;
            char_count <= '0;
            err_count  <= '0;
        end else begin
            in_ready <= ~freeze;
            s1_vld   <= in_valid & in_ready;
            if (in_valid & in_ready) begin
                s1_len <= char_len;
                s1_dat <= char_data & mask;
            end
            s2_vld   <= s1_vld;
            s2_op    <= dec_op;
            s2_glyph <= dec_glyph;
            s2_err   <= dec_err;
            if (s2_vld) begin
                case (s2_op)
                    OP_SHIFT: begin
                        seg <= {seg[8*NUM_DIGITS-9:0], s2_glyph};
                        if (char_count != CW'(NUM_DIGITS))
                            char_count <= char_count + CW'(1);
                        if (s2_err && (err_count != '1))
                            err_count <= err_count + ERR_W'(1);
                    end
                    // An empty buffer ignores backspace entirely.
                    OP_BKSP: begin
                        if (char_count != '0) begin
                            seg        <= {BLANK, seg[8*NUM_DIGITS-1:8]};
                            char_count <= char_count - CW'(1);
                        end
                    end
                    OP_CLEAR: begin
                        seg        <= '1;
                        char_count <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
